// File: rtl/serial_addsub_if.sv
// serial_addsub_if: operand/result bundle for the bit-serial adder/subtractor.
// master = requester, slave = serial_addsub.
interface serial_addsub_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, c_out, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, c_out, ovf
  );
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial WIDTH-bit add/sub, one full adder reused LSB first.
// Define ADDSUB_SAT_EN to saturate the result on signed overflow.
module serial_addsub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  serial_addsub_if.slave   bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int AW = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic             w_load;
  logic             w_busy;
  logic             w_done;

  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [AW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_res;
  logic             r_cout;
  logic             r_ovf;

  logic             w_last;
  logic             w_s;
  logic             w_cn;
  logic             w_ovf;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_res;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_load    = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load    = 1'b1;
          w_state_n = SHIFT;
        end
      end
      SHIFT: begin
        w_busy = 1'b1;
        if (w_last) w_state_n = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        if (bus.start) begin
          w_load    = 1'b1;
          w_state_n = SHIFT;
        end else begin
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign w_s    = r_opa[0] ^ r_opb[0] ^ r_carry;
  assign w_cn   = (r_opa[0] & r_opb[0]) |
                  (r_opa[0] & r_carry)  |
                  (r_opb[0] & r_carry);
  // r_carry is the carry into the MSB while the last bit is processed
  assign w_ovf  = r_carry ^ w_cn;
  assign w_sum  = {w_s, r_acc};

`ifdef ADDSUB_SAT_EN
  // r_opa[0] still holds the original A sign on the last bit
  always_comb begin
    w_res = w_sum;
    if (w_ovf) begin
      w_res = r_opa[0] ? {1'b1, {AW{1'b0}}}
                       : {1'b0, {AW{1'b1}}};
    end
  end
`else
  assign w_res = w_sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_res   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_opa   <= bus.a;
      r_opb   <= bus.b ^ {WIDTH{bus.sub}};
      r_carry <= bus.sub;
      r_cnt   <= '0;
    end else if (r_state == SHIFT) begin
      r_opa   <= r_opa >> 1;
      r_opb   <= r_opb >> 1;
      r_carry <= w_cn;
      r_acc   <= AW'({w_s, r_acc} >> 1);
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_res  <= w_res;
        r_cout <= w_cn;
        r_ovf  <= w_ovf;
      end
    end
  end

  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.result = r_res;
  assign bus.c_out  = r_cout;
  assign bus.ovf    = r_ovf;
endmodule
